pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive end of the pwm_generator link: samples a single-bit PWM line and recovers the
//  BIT_W-bit duty value that produced it, one result per PWM period. Used for loop-back
//  self-check of the LED colour PWM path and as the golden monitor in display benches.
//  Flags malformed periods and a stuck-high line.
// PARAMETERS
//  SYS_CLK_FREQ  100_000_000  clk_in frequency, Hz
//  PWM_FREQ      20_480       nominal PWM period frequency, Hz
//  BIT_W         8            duty resolution; period = PERIOD_STEPS = 2**BIT_W steps
//  SIMULATION    0            1: STEP_CYCLES forced to 2 for fast benches
// PORTS
//  clk_in          in   1      system clock
//  n_reset_in      in   1      asynchronous, active-low reset
//  pwm_in          in   1      PWM line (asynchronous to clk_in; synchronised internally)
//  duty_out        out  BIT_W  last recovered duty value (held between updates)
//  duty_valid_out  out  1      1-cycle pulse when duty_out is updated
//  period_err_out  out  1      1-cycle pulse: measured period outside PERIOD_STEPS +/-1
//  stuck_err_out   out  1      1-cycle pulse: line high longer than PERIOD_STEPS steps
//  locked_out      out  1      high after 2 consecutive good periods; low on any error
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> IDLE; sync flops 0; counters 0.
//  - STEP_CYCLES = SYS_CLK_FREQ/(PWM_FREQ*2**BIT_W) (integer, min 1; 19 at defaults).
//    Duty D means D high steps out of PERIOD_STEPS; D=0 gives no edges.
//  - pwm_in -> 2-flop sync -> edge detect (rise/fall pulses). Both edges see same delay.
//  - Counters: sub_cnt 0..STEP_CYCLES-1 wraps, advancing step_cnt (width BIT_W+2) and,
//    while line high, high_steps. Both clear on every accepted rising edge.
//  - FSM: IDLE  -> rise: clear counters, -> HIGH (first period never reported).
//         HIGH  -> fall: -> LOW. step_cnt > PERIOD_STEPS: stuck_err pulse, locked=0, -> IDLE.
//         LOW   -> rise: period end, evaluate, clear counters, -> HIGH.
//         IDLE/LOW: step_cnt reaches 2*PERIOD_STEPS with line low: duty_out=0,
//         duty_valid pulse, step_cnt cleared, stay/-> IDLE (repeats every 2*PERIOD_STEPS).
//  - Evaluation at period end (rise while LOW): if step_cnt (rounded) in
//    [PERIOD_STEPS-1, PERIOD_STEPS+1]: duty_out = high_steps + (sub_cnt_at_fall >=
//    STEP_CYCLES/2), saturated to 2**BIT_W-1; duty_valid pulse; good-count++ (sat at 2).
//    Else: period_err pulse, duty_out held, locked=0, good-count=0.
//  - Latency: duty_valid asserts exactly 4 clk_in cycles after the pwm_in rising edge
//    that closes the period (2 sync + 1 detect + 1 output register).
//  - Simultaneous timeout and rise in same cycle: rise wins (period evaluated).
//  - Pulse outputs never assert together except period_err with locked_out falling.
//  - Reset mid-period: everything cleared; next period after first rise is discarded.
//  - No backpressure: consumer must sample duty_out on duty_valid_out.
// STRUCTURE
//  - led_display_package: function pwm_step_cycles(sys_clk, pwm_freq, bit_w, sim),
//    shared with pwm_generator so both ends agree; typedef enum pwm_dec_state_t
//    {PWM_DEC_IDLE, PWM_DEC_HIGH, PWM_DEC_LOW}.
//  - One sub-module: sync_edge_detect (2-flop sync + rise/fall pulses), reusable.
//  - Remaining counters/FSM in this module.
// TESTING
//  All with SIMULATION=1 (STEP_CYCLES=2, period 512 clk), pwm_generator in loop-back.
//  1 colour_in=0x80 -> after 2nd rise, duty_out=0x80, duty_valid every 512 clk; locked=1
//    after 3rd rise.
//  2 colour_in=0x00 -> no edges; duty_valid with duty_out=0x00 every 1024 clk after reset.
//  3 Sweep colour_in 0x01..0xFF, 3 periods each -> each reported value equals colour_in
//    (0x01 and 0xFF included); no error pulses.
//  4 Direct drive: high 100 steps, low 50 steps, rise -> period_err pulse, duty_out
//    unchanged, locked_out=0; next good period re-locks after 2 good periods.
//  5 Hold pwm_in=1 for 600 clk -> stuck_err pulse at step 257, FSM IDLE, locked_out=0.
//  6 Assert n_reset_in mid-HIGH of 0x40 stream -> outputs 0 immediately; first period
//    after release discarded; duty_out=0x40 on the following rise.

Source files
------------

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared PWM link definitions: step timing helper used by both ends of the link
// and the decoder FSM state type.
package led_display_package;

  typedef enum logic [1:0] {
    PWM_DEC_IDLE,
    PWM_DEC_HIGH,
    PWM_DEC_LOW
  } pwm_dec_state_t;

  // Clock cycles per PWM step; simulation builds use a short fixed step.
  function automatic int unsigned pwm_step_cycles(
    input longint unsigned sys_clk,
    input longint unsigned pwm_freq,
    input int unsigned     bit_w,
    input bit              sim
  );
    longint unsigned cycles;
    if (sim) return 2;
    cycles = sys_clk / (pwm_freq << bit_w);
    if (cycles < 1) cycles = 1;
    return 32'(cycles);
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_sync.sv
// Two-flop synchroniser with registered rise/fall pulses. The level output is
// aligned with the pulses so both edges see the same delay.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain; blocking
      // ones would collapse the synchroniser into a single flop.
      meta   <= sig;
      stable <= meta;
      level  <= stable;
      rise   <= stable & ~level;
      fall   <= ~stable & level;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty value of a sampled PWM line, one result per period, and
// flags malformed periods and a stuck-high line.
module pwm_duty_decoder
  import led_display_package::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ     = 20_480,
  parameter int unsigned BIT_W        = 8,
  parameter bit          SIMULATION   = 1'b0
) (
  input  logic             clk_in,
  input  logic             n_reset_in,
  input  logic             pwm_in,
  output logic [BIT_W-1:0] duty_out,
  output logic             duty_valid_out,
  output logic             period_err_out,
  output logic             stuck_err_out,
  output logic             locked_out
);

  localparam int unsigned STEP_CYCLES  = pwm_step_cycles(64'(SYS_CLK_FREQ), 64'(PWM_FREQ),
                                                         BIT_W, SIMULATION);
  localparam int unsigned PERIOD_STEPS = 1 << BIT_W;
  localparam int unsigned SUB_W        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned STEP_W       = BIT_W + 2;
  localparam int unsigned STEP_W1      = STEP_W + 1;
  localparam int unsigned HIGH_W       = BIT_W + 1;
  localparam int unsigned DUTY_W       = BIT_W + 2;

  localparam logic [SUB_W-1:0]   SUB_LAST     = SUB_W'(STEP_CYCLES - 1);
  localparam logic [SUB_W-1:0]   SUB_HALF     = SUB_W'(STEP_CYCLES / 2);
  localparam logic [STEP_W-1:0]  STEP_MAX     = '1;
  localparam logic [STEP_W-1:0]  STUCK_LIMIT  = STEP_W'(PERIOD_STEPS);
  localparam logic [STEP_W-1:0]  TIMEOUT_LAST = STEP_W'(2 * PERIOD_STEPS - 1);
  localparam logic [STEP_W1-1:0] PERIOD_MIN   = STEP_W1'(PERIOD_STEPS - 1);
  localparam logic [STEP_W1-1:0] PERIOD_MAX   = STEP_W1'(PERIOD_STEPS + 1);
  localparam logic [DUTY_W-1:0]  DUTY_MAX     = DUTY_W'(PERIOD_STEPS - 1);

  pwm_dec_state_t       state;
  logic                 level;
  logic                 rise;
  logic                 fall;
  logic [SUB_W-1:0]     sub_cnt;
  logic [SUB_W-1:0]     fall_sub;
  logic [STEP_W-1:0]    step_cnt;
  logic [HIGH_W-1:0]    high_steps;
  logic [1:0]           good_cnt;

  logic                 step_wrap;
  logic                 timeout;
  logic                 period_ok;
  logic [STEP_W1-1:0]   period_steps;
  logic [DUTY_W-1:0]    duty_sum;
  logic [BIT_W-1:0]     duty_sat;

  sync_edge_detect u_sync (
    .clk   (clk_in),
    .rst_n (n_reset_in),
    .sig   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Partial steps at the period end and at the falling edge round half-up.
  always_comb begin
    step_wrap    = (sub_cnt == SUB_LAST);
    timeout      = step_wrap && (step_cnt == TIMEOUT_LAST) && !level;
    period_steps = {1'b0, step_cnt} + STEP_W1'(sub_cnt >= SUB_HALF);
    period_ok    = (period_steps >= PERIOD_MIN) && (period_steps <= PERIOD_MAX);
    duty_sum     = {1'b0, high_steps} + DUTY_W'(fall_sub >= SUB_HALF);
    duty_sat     = (duty_sum > DUTY_MAX) ? '1 : duty_sum[BIT_W-1:0];
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state          <= PWM_DEC_IDLE;
      sub_cnt        <= '0;
      fall_sub       <= '0;
      step_cnt       <= '0;
      high_steps     <= '0;
      good_cnt       <= '0;
      duty_out       <= '0;
      duty_valid_out <= 1'b0;
      period_err_out <= 1'b0;
      stuck_err_out  <= 1'b0;
      locked_out     <= 1'b0;
    end else begin
      duty_valid_out <= 1'b0;
      period_err_out <= 1'b0;
      stuck_err_out  <= 1'b0;

      // Free-running step timebase; step_cnt saturates rather than wrapping.
      if (step_wrap) begin
        sub_cnt <= '0;
        if (step_cnt != STEP_MAX) step_cnt <= step_cnt + STEP_W'(1);
        if (level) high_steps <= high_steps + HIGH_W'(1);
      end else begin
        sub_cnt <= sub_cnt + SUB_W'(1);
      end

      // NOTE: the clears below are later non-blocking assignments to the same
      // counters, so they override the timebase increments in the same cycle.
      case (state)
        PWM_DEC_IDLE: begin
          if (rise) begin
            sub_cnt    <= '0;
            step_cnt   <= '0;
            high_steps <= '0;
            state      <= PWM_DEC_HIGH;
          end else if (level) begin
            step_cnt <= '0;
          end else if (timeout) begin
            duty_out       <= '0;
            duty_valid_out <= 1'b1;
            step_cnt       <= '0;
          end
        end

        PWM_DEC_HIGH: begin
          if (fall) begin
            fall_sub <= sub_cnt;
            state    <= PWM_DEC_LOW;
          end else if (step_cnt > STUCK_LIMIT) begin
            stuck_err_out <= 1'b1;
            locked_out    <= 1'b0;
            good_cnt      <= '0;
            step_cnt      <= '0;
            state         <= PWM_DEC_IDLE;
          end
        end

        PWM_DEC_LOW: begin
          if (rise) begin
            if (period_ok) begin
              duty_out       <= duty_sat;
              duty_valid_out <= 1'b1;
              if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
              locked_out     <= (good_cnt != 2'd0);
            end else begin
              period_err_out <= 1'b1;
              locked_out     <= 1'b0;
              good_cnt       <= '0;
            end
            sub_cnt    <= '0;
            step_cnt   <= '0;
            high_steps <= '0;
            state      <= PWM_DEC_HIGH;
          end else if (timeout) begin
            duty_out       <= '0;
            duty_valid_out <= 1'b1;
            step_cnt       <= '0;
            state          <= PWM_DEC_IDLE;
          end
        end

        default: state <= PWM_DEC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: randomized PWM periods driven
// directly, checked against a period-level reference model.
module tb_pwm_duty_decoder;

  localparam int BIT_W = 8;
  localparam int STEP  = 2;
  localparam int P     = 256;

  logic             clk_in     = 1'b0;
  logic             n_reset_in = 1'b1;
  logic             pwm_in     = 1'b0;
  logic [BIT_W-1:0] duty_out;
  logic             duty_valid_out;
  logic             period_err_out;
  logic             stuck_err_out;
  logic             locked_out;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc       = 0;
  int n_valid   = 0;
  int n_perr    = 0;
  int n_serr    = 0;
  int n_overlap = 0;
  int exp_valid = 0;
  int exp_perr  = 0;
  int exp_serr  = 0;

  bit               have_start = 1'b0;
  int               last_rise  = 0;
  int               last_fall  = 0;
  int               good       = 0;
  logic [BIT_W-1:0] exp_duty   = '0;

  pwm_duty_decoder #(
    .SYS_CLK_FREQ (100_000_000),
    .PWM_FREQ     (20_480),
    .BIT_W        (BIT_W),
    .SIMULATION   (1'b1)
  ) dut (
    .clk_in         (clk_in),
    .n_reset_in     (n_reset_in),
    .pwm_in         (pwm_in),
    .duty_out       (duty_out),
    .duty_valid_out (duty_valid_out),
    .period_err_out (period_err_out),
    .stuck_err_out  (stuck_err_out),
    .locked_out     (locked_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (duty_valid_out) n_valid = n_valid + 1;
    if (period_err_out) n_perr = n_perr + 1;
    if (stuck_err_out) n_serr = n_serr + 1;
    if ((32'(duty_valid_out) + 32'(period_err_out) + 32'(stuck_err_out)) > 1)
      n_overlap = n_overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_duty"}, 32'(duty_out), 32'(exp_duty));
    check({tag, "_valid"}, 32'(duty_valid_out), 0);
    check({tag, "_perr"}, 32'(period_err_out), 0);
    check({tag, "_serr"}, 32'(stuck_err_out), 0);
    check({tag, "_locked"}, 32'(locked_out), 0);
  endtask

  task automatic model_reset();
    have_start = 1'b0;
    good       = 0;
    exp_duty   = '0;
  endtask

  task automatic apply_reset();
    pwm_in     = 1'b0;
    n_reset_in = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("rst");
    repeat (3) tick();
    n_reset_in = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_cnt"}, 32'(n_valid), 32'(exp_valid));
    check({tag, "_perr_cnt"}, 32'(n_perr), 32'(exp_perr));
    check({tag, "_serr_cnt"}, 32'(n_serr), 32'(exp_serr));
    check({tag, "_overlap"}, 32'(n_overlap), 0);
  endtask

  // Reference: a rise closes the period begun by the previous accepted rise.
  task automatic model_rise(output bit ev_valid, output bit ev_perr);
    int per;
    int hi;
    ev_valid = 1'b0;
    ev_perr  = 1'b0;
    if (have_start) begin
      per = (cyc - last_rise) / STEP;
      hi  = (last_fall - last_rise) / STEP;
      if (per >= P - 1 && per <= P + 1) begin
        ev_valid = 1'b1;
        exp_duty = (hi > P - 1) ? 8'hFF : 8'(hi);
        if (good < 2) good++;
      end else begin
        ev_perr = 1'b1;
        good    = 0;
      end
    end
    have_start = 1'b1;
    last_rise  = cyc;
    exp_valid += int'(ev_valid);
    exp_perr  += int'(ev_perr);
  endtask

  task automatic check_rise_result(input bit ev_valid, input bit ev_perr);
    check("valid", 32'(duty_valid_out), 32'(ev_valid));
    check("perr", 32'(period_err_out), 32'(ev_perr));
    check("duty", 32'(duty_out), 32'(exp_duty));
    check("locked", 32'(locked_out), 32'(good == 2));
  endtask

  // One period: hi steps high then lo steps low; results checked 4 clk after the rise.
  task automatic drive_period(input int hi, input int lo);
    int len;
    int stuck_at;
    bit ev_valid;
    bit ev_perr;
    len      = (hi + lo) * STEP;
    stuck_at = -1;
    model_rise(ev_valid, ev_perr);
    for (int k = 0; k < len; k++) begin
      if (k == 0) pwm_in = 1'b1;
      if (k == hi * STEP) begin
        pwm_in    = 1'b0;
        last_fall = cyc;
      end
      if (k == 4) check_rise_result(ev_valid, ev_perr);
      if (stuck_err_out && stuck_at < 0) stuck_at = k;
      tick();
    end
    if (hi > P) begin
      check("stuck_near_step_257", 32'(stuck_at >= 514 && stuck_at <= 522), 1);
      exp_serr++;
      have_start = 1'b0;
      good       = 0;
      check("stuck_locked", 32'(locked_out), 0);
    end
  endtask

  initial begin
    int hi_tab[9] = '{1, 255, 2, 254, 100, 256, 100, 100, 128};
    int lo_tab[9] = '{255, 1, 254, 1, 157, 1, 154, 158, 128};
    int hi;
    int lo;

    // Reset state and a steady mid-scale stream
    tick();
    apply_reset();
    repeat (4) drive_period(8'h80, P - 8'h80);
    check_counts("t1");

    // Line never toggles: zero duty reported every 2*P steps
    apply_reset();
    repeat (2) begin
      repeat (2 * P * STEP - 1) tick();
      check("zero_quiet", 32'(duty_valid_out), 0);
      tick();
      check("zero_valid", 32'(duty_valid_out), 1);
      check("zero_duty", 32'(duty_out), 0);
      exp_valid++;
    end
    check_counts("t2");

    // Boundary periods, then randomized good and malformed periods
    apply_reset();
    for (int i = 0; i < 9; i++) drive_period(hi_tab[i], lo_tab[i]);
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        hi = int'($urandom_range(200, 1));
        lo = int'($urandom_range(200, 1));
        if (hi + lo >= P - 1 && hi + lo <= P + 1) lo += 10;
      end else begin
        hi = int'($urandom_range(255, 1));
        lo = P - hi;
      end
      drive_period(hi, lo);
    end
    drive_period(8'h40, P - 8'h40);
    check_counts("t3");

    // Malformed period breaks lock; two good periods restore it
    apply_reset();
    repeat (3) drive_period(8'h30, P - 8'h30);
    drive_period(100, 50);
    repeat (4) drive_period(8'hA0, P - 8'hA0);
    check_counts("t4");

    // Stuck-high line
    apply_reset();
    repeat (3) drive_period(8'h80, P - 8'h80);
    drive_period(300, 20);
    repeat (4) drive_period(8'h10, P - 8'h10);
    check_counts("t5");

    // Reset in the middle of a high phase
    apply_reset();
    repeat (3) drive_period(8'h40, P - 8'h40);
    begin
      bit ev_valid;
      bit ev_perr;
      model_rise(ev_valid, ev_perr);
      pwm_in = 1'b1;
      repeat (4) tick();
      check_rise_result(ev_valid, ev_perr);
      repeat (16) tick();
      n_reset_in = 1'b0;
      #1;
      model_reset();
      check_idle_outputs("midrst");
      repeat (2 * 8'h40 - 20) tick();
      pwm_in = 1'b0;
      repeat (10) tick();
      n_reset_in = 1'b1;
      repeat (2 * (P - 8'h40) - 10) tick();
    end
    repeat (3) drive_period(8'h40, P - 8'h40);
    check("midrst_final_duty", 32'(duty_out), 32'h40);
    check_counts("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
